serial_alu: RTL

Multi-cycle, parametrised N-bit ALU for the MIPS datapath. It processes operands DIGIT bits per cycle, least-significant digit first, through a ripple slice, so ALU area trades against latency. It uses the same 4-bit op encoding and function set as the single-bit ALU cell (AND, OR, ADD, SUB, SLT, NOR) and adds the whole-word flags. It sits between the register-read stage and writeback, behind a valid/ready handshake on both sides.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/serial_alu_if.sv | 27 ++
 rtl/alu_digit_slice.sv | 48 ++++
 rtl/serial_alu.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the digit-serial ALU: op codes, FSM states and op legality.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_SLT = 4'd7;
    localparam logic [3:0] OP_NOR = 4'd12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: is_legal_op = 1'b1;
            default:                                      is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/serial_alu_if.sv
// Operand/result handshake bundle between the register-read stage, the serial ALU and writeback.
interface serial_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             overflow;
    logic             illegal;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, zero, carry, overflow, illegal
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, zero, carry, overflow, illegal
    );
endinterface

// File: rtl/alu_digit_slice.sv
// Combinational DIGIT-bit ALU slice; cout is carry for ADD and borrow for SUB/SLT.
module alu_digit_slice
    import alu_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [3:0]       op,
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             cin,
    output logic [DIGIT-1:0] r_d,
    output logic             cout,
    output logic             msb
);

    logic [DIGIT:0] cin_ext_s;
    logic [DIGIT:0] sum_s;
    logic [DIGIT:0] diff_s;

    assign cin_ext_s = {{DIGIT{1'b0}}, cin};
    assign sum_s     = {1'b0, a_d} + {1'b0, b_d} + cin_ext_s;
    // The extra top bit of an unsigned (DIGIT+1)-bit subtraction is the borrow out
    assign diff_s    = {1'b0, a_d} - {1'b0, b_d} - cin_ext_s;

    // Per-op digit result and chain output
    always_comb begin
        r_d  = {DIGIT{1'b0}};
        cout = 1'b0;
        msb  = 1'b0;
        case (op)
            OP_AND: r_d = a_d & b_d;
            OP_OR:  r_d = a_d | b_d;
            OP_NOR: r_d = ~(a_d | b_d);
            OP_ADD: begin
                r_d  = sum_s[DIGIT-1:0];
                cout = sum_s[DIGIT];
                msb  = sum_s[DIGIT-1];
            end
            OP_SUB, OP_SLT: begin
                r_d  = diff_s[DIGIT-1:0];
                cout = diff_s[DIGIT];
                msb  = diff_s[DIGIT-1];
            end
            default: r_d = {DIGIT{1'b0}};
        endcase
    end

endmodule

// File: rtl/serial_alu.sv
// Digit-serial N-bit ALU: LS digit first through one slice, whole-word flags latched on entry to DONE.
module serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    serial_alu_if.slave bus
);

    localparam int             NDIG     = WIDTH / DIGIT;
    localparam int             CW       = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0]  LAST_DIG = CW'(NDIG - 1);

    state_t                 state_r, state_s;
    logic [3:0]             op_r;
    logic [WIDTH-1:0]       a_sh_r, b_sh_r, acc_r;
    logic                   cy_r;
    logic [CW-1:0]          cnt_r;
    logic [WIDTH-1:0]       result_r;
    logic                   zero_r, carry_r, ovf_r, illegal_r;
    logic                   in_ready_r, out_valid_r;

    logic [DIGIT-1:0]       r_d_s;
    logic                   cout_s, msb_s;
    logic [WIDTH+DIGIT-1:0] shift_s;
    logic [WIDTH-1:0]       acc_next_s;
    logic                   last_s;
    logic                   a_msb_s, b_msb_s, ovf_add_s, ovf_sub_s;
    logic [WIDTH-1:0]       fin_res_s;
    logic                   fin_cy_s, fin_ovf_s;

    alu_digit_slice #(.DIGIT(DIGIT)) u_slice (
        .op   (op_r),
        .a_d  (a_sh_r[DIGIT-1:0]),
        .b_d  (b_sh_r[DIGIT-1:0]),
        .cin  (cy_r),
        .r_d  (r_d_s),
        .cout (cout_s),
        .msb  (msb_s)
    );

    assign shift_s    = {r_d_s, acc_r};
    assign acc_next_s = shift_s[WIDTH+DIGIT-1:DIGIT];
    assign last_s     = (state_r == RUN) && (cnt_r == LAST_DIG);

    // On the last digit the shifted operands expose their original MSBs in the low digit
    always_comb begin
        a_msb_s   = a_sh_r[DIGIT-1];
        b_msb_s   = b_sh_r[DIGIT-1];
        ovf_add_s = (a_msb_s == b_msb_s) && (msb_s != a_msb_s);
        ovf_sub_s = (a_msb_s != b_msb_s) && (msb_s != a_msb_s);
        fin_res_s = {WIDTH{1'b0}};
        fin_cy_s  = 1'b0;
        fin_ovf_s = 1'b0;
        case (op_r)
            OP_ADD: begin
                fin_res_s = acc_next_s;
                fin_cy_s  = cout_s;
                fin_ovf_s = ovf_add_s;
            end
            OP_SUB: begin
                fin_res_s = acc_next_s;
                fin_cy_s  = cout_s;
                fin_ovf_s = ovf_sub_s;
            end
            OP_SLT: begin
                fin_res_s = {{(WIDTH-1){1'b0}}, msb_s ^ ovf_sub_s};
                fin_cy_s  = cout_s;
            end
            OP_AND, OP_OR, OP_NOR: fin_res_s = acc_next_s;
            default:               fin_res_s = {WIDTH{1'b0}};
        endcase
    end

    // FSM next-state
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: if (bus.in_valid) state_s = RUN;  else state_s = IDLE;
            RUN:  if (last_s)       state_s = DONE; else state_s = RUN;
            DONE: if (bus.out_ready) state_s = IDLE; else state_s = DONE;
            default: state_s = IDLE;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            op_r        <= 4'd0;
            a_sh_r      <= {WIDTH{1'b0}};
            b_sh_r      <= {WIDTH{1'b0}};
            acc_r       <= {WIDTH{1'b0}};
            cy_r        <= 1'b0;
            cnt_r       <= {CW{1'b0}};
            result_r    <= {WIDTH{1'b0}};
            zero_r      <= 1'b0;
            carry_r     <= 1'b0;
            ovf_r       <= 1'b0;
            illegal_r   <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == DONE);
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_r   <= bus.op;
                        a_sh_r <= bus.a;
                        b_sh_r <= bus.b;
                        acc_r  <= {WIDTH{1'b0}};
                        cy_r   <= 1'b0;
                        cnt_r  <= {CW{1'b0}};
                    end else begin
                        cnt_r  <= cnt_r;
                    end
                end
                RUN: begin
                    acc_r  <= acc_next_s;
                    a_sh_r <= a_sh_r >> DIGIT;
                    b_sh_r <= b_sh_r >> DIGIT;
                    cy_r   <= cout_s;
                    cnt_r  <= cnt_r + CW'(1);
                    if (last_s) begin
                        result_r  <= fin_res_s;
                        zero_r    <= (fin_res_s == {WIDTH{1'b0}});
                        carry_r   <= fin_cy_s;
                        ovf_r     <= fin_ovf_s;
                        illegal_r <= ~is_legal_op(op_r);
                    end else begin
                        result_r  <= result_r;
                    end
                end
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.zero      = zero_r;
    assign bus.carry     = carry_r;
    assign bus.overflow  = ovf_r;
    assign bus.illegal   = illegal_r;

endmodule
